// File: rtl/fpmul_issuer.sv
// Operand-FIFO front end and Start/Done sequencer for the multi-cycle FPMUL unit.
// One request is in flight at a time. A missing Done is turned into a flagged timeout result.
module fpmul_issuer #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                     Clk,
    input  logic                     Rst,
    input  logic                     In_Valid,
    output logic                     In_Ready,
    input  logic [31:0]              In_A,
    input  logic [31:0]              In_B,
    output logic                     Mul_Start,
    output logic [31:0]              Mul_A,
    output logic [31:0]              Mul_B,
    input  logic                     Mul_Done,
    input  logic [31:0]              Mul_P,
    input  logic [5:0]               Mul_Flags,
    output logic                     Out_Valid,
    input  logic                     Out_Ready,
    output logic [31:0]              Out_P,
    output logic [5:0]               Out_Flags,
    output logic                     Out_Timeout,
    output logic                     Busy,
    output logic [$clog2(DEPTH):0]   Count
);
    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_HOLD  = 2'd3;

    logic [63:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q, count_d;
    logic [1:0]    state_q, state_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic [31:0]   mul_a_q, mul_a_d, mul_b_q, mul_b_d;
    logic [31:0]   out_p_q, out_p_d;
    logic [5:0]    out_f_q, out_f_d;
    logic          out_t_q, out_t_d;
    logic          out_v_q, out_v_d;
    logic          push, pop;
    logic [63:0]   head;

    // In_Ready is gated by Rst so nothing is accepted while the pointers are held.
    assign In_Ready  = (count_q != FULL_CNT) && !Rst;
    assign push      = In_Valid && In_Ready;
    assign head      = mem_q[rd_ptr_q];
    assign Mul_Start = (state_q == S_ISSUE);
    assign Mul_A     = mul_a_q;
    assign Mul_B     = mul_b_q;
    assign Out_Valid = out_v_q;
    assign Out_P     = out_p_q;
    assign Out_Flags = out_f_q;
    assign Out_Timeout = out_t_q;
    assign Count     = count_q;
    assign Busy      = (state_q != S_IDLE) || (count_q != '0);

    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        mul_a_d = mul_a_q;
        mul_b_d = mul_b_q;
        out_p_d = out_p_q;
        out_f_d = out_f_q;
        out_t_d = out_t_q;
        out_v_d = out_v_q;
        pop     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (count_q != '0) begin
                    mul_a_d = head[63:32];
                    mul_b_d = head[31:0];
                    pop     = 1'b1;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                tmr_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                tmr_d = tmr_q + TW'(1);
                // Done takes priority over an expiring timer on the same cycle.
                if (Mul_Done) begin
                    out_p_d = Mul_P;
                    out_f_d = Mul_Flags;
                    out_t_d = 1'b0;
                    out_v_d = 1'b1;
                    state_d = S_HOLD;
                end else if (tmr_q == TMO_LAST) begin
                    out_p_d = '0;
                    out_f_d = '0;
                    out_t_d = 1'b1;
                    out_v_d = 1'b1;
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (Out_Ready) begin
                    out_v_d = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (push) mem_q[wr_ptr_q] <= {In_A, In_B};
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            state_q  <= S_IDLE;
            tmr_q    <= '0;
            mul_a_q  <= '0;
            mul_b_q  <= '0;
            out_p_q  <= '0;
            out_f_q  <= '0;
            out_t_q  <= 1'b0;
            out_v_q  <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
            state_q <= state_d;
            tmr_q   <= tmr_d;
            mul_a_q <= mul_a_d;
            mul_b_q <= mul_b_d;
            out_p_q <= out_p_d;
            out_f_q <= out_f_d;
            out_t_q <= out_t_d;
            out_v_q <= out_v_d;
        end
    end
endmodule
